clk_cross_fifo: RTL and testbench



---
 rtl/clk_cross_fifo_pkg.sv | 15 +
 rtl/fifo_ram.sv | 27 ++
 rtl/clk_cross_fifo.sv | 83 ++++++++
 tb/tb_clk_cross_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_cross_fifo_pkg.sv
// Shared helpers for the single-clock FWFT FIFO and its storage array.
// Pointer and counter widths are derived from Depth through log2 below.
package clk_cross_fifo_pkg;

  // Ceiling log2; Depth is a power of two, so this is exact.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with registered read, no reset on the array so it maps to block RAM.
// A read of an address written on the same edge returns the old contents.
module fifo_ram
  import clk_cross_fifo_pkg::*;
#(
  parameter int Width = 512,
  parameter int Depth = 512
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [log2(Depth)-1:0] waddr,
  input  logic [Width-1:0]       wdata,
  input  logic [log2(Depth)-1:0] raddr,
  output logic [Width-1:0]       rdata
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/clk_cross_fifo.sv
// Single-clock first-word-fall-through FIFO; the RAM read register is the output stage.
// Capacity is Depth words including the word presented on dout.
module clk_cross_fifo
  import clk_cross_fifo_pkg::*;
#(
  parameter int Width = 512,
  parameter int Depth = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [Width-1:0] dout,
  input  logic             rd_en,
  output logic             valid
);

  localparam int AW = log2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(Depth);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;
  logic             wr_acc, rd_acc;
  logic [Width-1:0] ram_rdata;

  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == FullCount);
    // The RAM register can only present a word that was stored before this edge,
    // so a word written into the next-head slot on this edge shows up one edge later.
    valid_d = rd_acc ? (count_q > CW'(1)) : (count_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

  // Read address tracks the head after this edge's pop, keeping dout fall-through.
  fifo_ram #(
    .Width(Width),
    .Depth(Depth)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_d),
    .rdata(ram_rdata)
  );

  assign full  = full_q;
  assign valid = valid_q;
  assign dout  = valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_clk_cross_fifo.sv
// Bench for clk_cross_fifo: 512-bit and 128-bit instances driven in lockstep,
// checked every cycle against a queue model with per-word write timestamps.
module tb_clk_cross_fifo;

  localparam int Depth = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [511:0] din_a = '0;
  logic [127:0] din_b = '0;
  logic         full_a, valid_a, full_b, valid_b;
  logic [511:0] dout_a;
  logic [127:0] dout_b;

  always #5 clk = ~clk;

  clk_cross_fifo #(.Width(512), .Depth(Depth)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .wr_en(wr_en), .full(full_a),
    .dout(dout_a), .rd_en(rd_en), .valid(valid_a)
  );

  clk_cross_fifo #(.Width(128), .Depth(Depth)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .wr_en(wr_en), .full(full_b),
    .dout(dout_b), .rd_en(rd_en), .valid(valid_b)
  );

  // Model: queue of stored words, each stamped with the edge that wrote it.
  typedef struct {
    logic [511:0] d;
    int           stamp;
  } ent_t;

  ent_t         q[$];
  int           edge_cnt = 0;
  int           ncmp = 0;
  int           nerr = 0;
  logic [511:0] words [Depth];

  function automatic logic m_valid();
    return (q.size() > 0) && (q[0].stamp < edge_cnt);
  endfunction

  function automatic logic m_full();
    return q.size() == Depth;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic w, input logic r, input logic [511:0] d);
    logic wacc, racc;
    wacc = w && !m_full();
    racc = r && m_valid();
    edge_cnt++;
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back('{d: d, stamp: edge_cnt});
  endtask

  task automatic check_all(input string tag);
    logic mv, mf;
    mv = m_valid();
    mf = m_full();
    chk({tag, "_valid_a"}, 512'(valid_a), 512'(mv));
    chk({tag, "_valid_b"}, 512'(valid_b), 512'(mv));
    chk({tag, "_full_a"},  512'(full_a),  512'(mf));
    chk({tag, "_full_b"},  512'(full_b),  512'(mf));
    if (mv) begin
      chk({tag, "_dout_a"}, dout_a, q[0].d);
      chk({tag, "_dout_b"}, 512'(dout_b), 512'(q[0].d[127:0]));
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [511:0] d);
    wr_en = w;
    rd_en = r;
    din_a = d;
    din_b = d[127:0];
    @(posedge clk);
    model_edge(w, r, d);
    #1;
    check_all("cyc");
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid_a"}, 512'(valid_a), 512'(0));
    chk({tag, "_valid_b"}, 512'(valid_b), 512'(0));
    chk({tag, "_full_a"},  512'(full_a),  512'(0));
    chk({tag, "_full_b"},  512'(full_b),  512'(0));
    chk({tag, "_dout_a"},  dout_a,        512'(0));
    chk({tag, "_dout_b"},  512'(dout_b),  512'(0));
  endtask

  // Asserts rst mid-cycle, away from any clock edge.
  task automatic do_reset(input string tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs(tag);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < Depth + 4; i++) begin
      if (q.size() == 0) break;
      step(1'b0, 1'b1, '0);
    end
    chk({tag, "_drained_valid"}, 512'(valid_a), 512'(0));
  endtask

  initial begin
    logic [511:0] xw, yw;
    int           nxt;
    int           pw, pr;

    // Power-on reset state.
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three writes, then popping shows them on consecutive cycles.
    step(1'b1, 1'b0, 512'(1));
    chk("s1_not_yet_valid", 512'(valid_a), 512'(0));
    step(1'b1, 1'b0, 512'(2));
    chk("s1_valid_after_1", 512'(valid_a), 512'(1));
    chk("s1_head_a", dout_a, 512'(1));
    chk("s1_head_b", 512'(dout_b), 512'(1));
    step(1'b1, 1'b0, 512'(3));
    step(1'b0, 1'b1, '0);
    chk("s1_pop1", dout_a, 512'(2));
    step(1'b0, 1'b1, '0);
    chk("s1_pop2", dout_a, 512'(3));
    chk("s1_pop2_b", 512'(dout_b), 512'(3));
    step(1'b0, 1'b1, '0);
    chk("s1_empty", 512'(valid_a), 512'(0));

    // Fill to capacity, drop one extra word, drain in order.
    do_reset("s2_reset");
    for (int i = 0; i < Depth; i++) begin
      words[i] = rnd512();
      step(1'b1, 1'b0, words[i]);
    end
    chk("s2_full_a", 512'(full_a), 512'(1));
    chk("s2_full_b", 512'(full_b), 512'(1));
    step(1'b1, 1'b0, rnd512());
    chk("s2_still_full", 512'(full_a), 512'(1));
    for (int k = 0; k < Depth; k++) begin
      chk("s2_order_a", dout_a, words[k]);
      chk("s2_order_b", 512'(dout_b), 512'(words[k][127:0]));
      step(1'b0, 1'b1, '0);
    end
    chk("s2_drained", 512'(valid_a), 512'(0));

    // From full, write+pop together: pop wins, write rejected.
    do_reset("s3_reset");
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, rnd512());
    xw = rnd512();
    yw = rnd512();
    step(1'b1, 1'b1, xw);
    chk("s3_full_cleared", 512'(full_a), 512'(0));
    step(1'b1, 1'b0, yw);
    chk("s3_refull", 512'(full_a), 512'(1));
    for (int i = 0; i < Depth - 1; i++) step(1'b0, 1'b1, '0);
    chk("s3_last_is_accepted_write", dout_a, yw);
    step(1'b0, 1'b1, '0);
    chk("s3_empty", 512'(valid_a), 512'(0));

    // Half full, sustained write+pop with incrementing data across pointer wrap.
    do_reset("s4_reset");
    for (int i = 0; i < Depth / 2; i++) step(1'b1, 1'b0, 512'(i));
    nxt = 0;
    for (int c = 0; c < 2000; c++) begin
      chk("s4_contig", dout_a, 512'(nxt));
      nxt++;
      step(1'b1, 1'b1, 512'(Depth / 2 + c));
    end
    chk("s4_not_full", 512'(full_a), 512'(0));
    drain_all("s4");

    // Reset mid-stream with 10 words stored discards everything.
    do_reset("s5_pre");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, rnd512());
    do_reset("s5_midstream");
    step(1'b1, 1'b0, 512'(10));
    step(1'b0, 1'b0, '0);
    chk("s5_valid", 512'(valid_a), 512'(1));
    chk("s5_dout_a", dout_a, 512'(10));
    chk("s5_dout_b", 512'(dout_b), 512'(10));
    step(1'b0, 1'b1, '0);
    chk("s5_no_old_data", 512'(valid_a), 512'(0));

    // Random traffic, alternating fill-biased and drain-biased phases.
    do_reset("rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      if (((c / 300) % 2) == 0) begin
        pw = 85;
        pr = 30;
      end else begin
        pw = 30;
        pr = 85;
      end
      step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr), rnd512());
    end
    drain_all("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
